rcl_arbiter: RTL
================

RCL_ARBITER -- requirements
Module: rcl_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (fixed at 4 in this release).
REQ-002 SHALL have parameter COEF_W, default 5, coefficient width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all flops rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req, input, 4 bits: req[i] high means requester i holds a pending job.
REQ-006 SHALL have port coef_L_bus, input, 60 bits: requester i's line coefficients in slice [15i+14:15i]; {c,b,a}, a in the low bits; each 5-bit signed.
REQ-007 SHALL have port coef_Q_bus, input, 60 bits: requester i's circle coefficients in slice [15i+14:15i]; {k,n,m}, m in the low bits; m and n signed, k unsigned.
REQ-008 SHALL have port gnt, output, 4 bits: one-hot one-cycle pulse marking the job accepted.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after capture until out_valid inclusive.
REQ-010 SHALL have port out_valid, output, 1 bit: one-cycle result strobe.
REQ-011 SHALL have port out_id, output, 2 bits: requester index of the result.
REQ-012 SHALL have port out, output, 2 bits: 0 = no intersection, 1 = tangent, 2 = two intersections.

Function
REQ-013 SHALL implement FSM IDLE -> FEED -> WAIT -> IDLE, registered state.
REQ-014 IDLE with req != 0 in cycle T: SHALL select the winner by round-robin, capture its 6 coefficients at the end of T, and enter FEED.
REQ-015 Round-robin SHALL search from pointer+1 upward, wrapping modulo 4; pointer SHALL update to the winner on capture.
REQ-016 gnt[winner] SHALL be high in cycle T+1 only; requester SHALL hold its coefficients stable through cycle T.
REQ-017 FEED SHALL drive the compute core with in_valid high in cycles T+1, T+2, T+3.
REQ-018 The feed order SHALL be (coef_L=a, coef_Q=m), then (b, n), then (c, k); the beat counter SHALL be 2 bits and SHALL wrap to 0 on leaving FEED.
REQ-019 WAIT SHALL hold in_valid low and exit when the core's out_valid is seen (cycle T+5).
REQ-020 On that edge the arbiter SHALL register the core result and winner id, so out_valid, out and out_id are high/valid in cycle T+6.
REQ-021 The FSM SHALL return to IDLE in cycle T+6, allowing the next capture at the end of T+6; minimum job spacing is 6 cycles, and the core never sees in_valid within 2 cycles after its out_valid.
REQ-022 req changes during FEED or WAIT SHALL be ignored until IDLE.
REQ-023 A requester keeping req high after gnt SHALL be treated as a new job.
REQ-024 The core result SHALL be (a*m+b*n+c)^2 compared with (a^2+b^2)*k, using signed arithmetic at full width: 11-bit sums, 16-bit r, 24-bit d; no truncation.
REQ-025 A core out_valid seen outside WAIT SHALL be ignored.
REQ-026 gnt and out_valid SHALL never be high in the same cycle for the same job.

Reset
REQ-027 While rst_n is low: state SHALL be IDLE, pointer 3 (requester 0 wins first), beat counter 0.
REQ-028 While rst_n is low: gnt, busy, out_valid, out_id and out SHALL all be 0, and the captured coefficients SHALL be 0.
REQ-029 Reset asserted mid-job SHALL discard the job with no out_valid; the core instance SHALL share rst_n.

Structure
REQ-030 Package rcl_arb_pkg SHALL hold NUM_REQ, COEF_W, the FSM state encodings and the result codes NONE=0, TANGENT=1, SECANT=2.
REQ-031 SHALL instantiate exactly one sub-module, the team's RCL circle-line core (module RCL).
REQ-032 The RCL core's contract: 3-beat in_valid input; out_valid 2 cycles after the last beat; next in_valid no earlier than 1 cycle after out_valid.
REQ-033 Arbitration, capture registers and output registers SHALL live in rcl_arbiter.

Verification
REQ-034 Single job: req=0001, a=1, b=0, c=0, m=3, n=0, k=4 captured in T -> gnt=0001 at T+1, out_valid at T+6, out=0, out_id=0.
REQ-035 Tangent and secant: the same line with m=2, k=4 -> out=1; with m=1, k=4 -> out=2.
REQ-036 Contention: req=1111 held for 4 jobs from reset -> grant order 0,1,2,3, outputs 6 cycles apart, out_id 0,1,2,3.
REQ-037 Signed extremes: a=b=c=m=n=-16, k=31 -> r=512*31=15872, d=(512-16)^2=246016 -> out=0 with no overflow.
REQ-038 Reset mid-job: rst_n low at T+3 for 1 cycle -> no out_valid, all outputs 0; the next req=0100 is granted with a correct result.
REQ-039 Late request: req=0010 raised in WAIT of a job from requester 0 -> requester 1 is not granted until the T+6 IDLE cycle, and gnt=0010 at T+7.

Source files
------------

// File: rtl/rcl_arb_pkg.sv
// Shared types and constants for the RCL arbiter slice: sizes, FSM state
// encodings, result codes and the final classification helper.
package rcl_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int COEF_W  = 5;

   // Full-width arithmetic: the affine sum needs 11 bits signed, the radius
   // term 16 bits and the squared distance 24 bits, so nothing is truncated.
   localparam int SUM_W = 11;
   localparam int R_W   = 16;
   localparam int D_W   = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FEED = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      TANGENT = 2'd1,
      SECANT  = 2'd2
   } res_t;

   // d is the squared signed distance term, r the scaled radius term.
   function automatic res_t classify(input logic signed [D_W-1:0] d,
                                     input logic signed [D_W-1:0] r);
      res_t res;
      if (d > r)
         res = NONE;
      else if (d == r)
         res = TANGENT;
      else
         res = SECANT;
      return res;
   endfunction

endpackage

// File: rtl/rcl_arbiter_if.sv
// Requester-side bus of the RCL arbiter: request vector, packed coefficient
// buses, one-hot grant and the registered result strobe.
interface rcl_arbiter_if #(
   parameter int NUM_REQ = rcl_arb_pkg::NUM_REQ,
   parameter int COEF_W  = rcl_arb_pkg::COEF_W
);

   logic [NUM_REQ-1:0]          req;
   logic [NUM_REQ*3*COEF_W-1:0] coef_L_bus;
   logic [NUM_REQ*3*COEF_W-1:0] coef_Q_bus;
   logic [NUM_REQ-1:0]          gnt;
   logic                        busy;
   logic                        out_valid;
   logic [1:0]                  out_id;
   logic [1:0]                  out;

   modport master (
      output req, coef_L_bus, coef_Q_bus,
      input  gnt, busy, out_valid, out_id, out
   );

   modport slave (
      input  req, coef_L_bus, coef_Q_bus,
      output gnt, busy, out_valid, out_id, out
   );

endinterface

// File: rtl/rcl_arbiter_rcl.sv
// RCL circle-line core. Takes three beats (a,m), (b,n), (c,k) and reports
// whether line a*x+b*y+c=0 misses, touches or cuts the circle centred on
// (m,n): (a*m+b*n+c)^2 is compared against (a^2+b^2)*k.
// out_valid rises two cycles after the last beat.
module RCL
   import rcl_arb_pkg::*;
#(
   parameter int COEF_W = rcl_arb_pkg::COEF_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [COEF_W-1:0] coef_L,
   input  logic [COEF_W-1:0] coef_Q,
   output logic              out_valid,
   output logic [1:0]        out
);

   logic [1:0]               beat;
   logic signed [COEF_W-1:0] a_r, b_r, m_r, n_r;
   logic signed [SUM_W-1:0]  s_r, q_r;
   logic [COEF_W-1:0]        k_r;
   logic                     s_valid;

   logic signed [SUM_W-1:0]  a_x, b_x, c_x, m_x, n_x;
   logic signed [SUM_W-1:0]  s_next, q_next;
   logic signed [D_W-1:0]    s_w, d_val, r_ext;
   logic signed [R_W-1:0]    q_w, k_w, r_val;

   // Sign-extend to the sum width and form the affine sum and a^2+b^2.
   always_comb begin
      a_x    = a_r;
      b_x    = b_r;
      m_x    = m_r;
      n_x    = n_r;
      c_x    = $signed(coef_L);
      s_next = a_x * m_x + b_x * n_x + c_x;
      q_next = a_x * a_x + b_x * b_x;
   end

   // Second stage: square the sum and scale the normal length by k (unsigned).
   always_comb begin
      s_w   = s_r;
      d_val = s_w * s_w;
      q_w   = q_r;
      k_w   = $signed({{(R_W-COEF_W){1'b0}}, k_r});
      r_val = q_w * k_w;
      r_ext = r_val;
   end

   // Beat collection; the third beat completes the first pipeline stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat    <= '0;
         a_r     <= '0;
         b_r     <= '0;
         m_r     <= '0;
         n_r     <= '0;
         s_r     <= '0;
         q_r     <= '0;
         k_r     <= '0;
         s_valid <= 1'b0;
      end else begin
         s_valid <= 1'b0;
         if (in_valid) begin
            case (beat)
               2'd0: begin
                  a_r  <= coef_L;
                  m_r  <= coef_Q;
                  beat <= 2'd1;
               end
               2'd1: begin
                  b_r  <= coef_L;
                  n_r  <= coef_Q;
                  beat <= 2'd2;
               end
               default: begin
                  s_r     <= s_next;
                  q_r     <= q_next;
                  k_r     <= coef_Q;
                  s_valid <= 1'b1;
                  beat    <= '0;
               end
            endcase
         end
      end
   end

   // Result register: classify and strobe one cycle after the first stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
      end else begin
         out_valid <= s_valid;
         if (s_valid)
            out <= classify(d_val, r_ext);
      end
   end

endmodule

// File: rtl/rcl_arbiter.sv
// Round-robin front end for a single RCL core. One job at a time: capture the
// winner's six coefficients, feed them as three beats, wait for the core and
// register its result with the winner's index.
module rcl_arbiter
   import rcl_arb_pkg::*;
#(
   parameter int NUM_REQ = rcl_arb_pkg::NUM_REQ,
   parameter int COEF_W  = rcl_arb_pkg::COEF_W
) (
   input  logic          clk,
   input  logic          rst_n,
   rcl_arbiter_if.slave  bus
);

   localparam int SLICE_W = 3 * COEF_W;

   state_t             state;
   logic [1:0]         ptr;
   logic [1:0]         beat;
   logic [1:0]         win;
   logic [1:0]         cand;
   logic               found;
   logic [NUM_REQ-1:0] gnt_next;
   logic [SLICE_W-1:0] sel_L, sel_Q;

   logic [COEF_W-1:0]  cap_a, cap_b, cap_c, cap_m, cap_n, cap_k;

   logic               core_in_valid;
   logic [COEF_W-1:0]  feed_L, feed_Q;
   logic               core_out_valid;
   logic [1:0]         core_out;

   logic [NUM_REQ-1:0] gnt_r;
   logic               busy_r;
   logic               out_valid_r;
   logic [1:0]         out_id_r;
   logic [1:0]         out_r;

   // Round-robin pick: first pending request after the pointer, wrapping.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      cand     = '0;
      gnt_next = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = ptr + 2'(i);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      if (found)
         gnt_next[win] = 1'b1;
   end

   // Winner's coefficient slices: {c,b,a} and {k,n,m}.
   always_comb begin
      sel_L = bus.coef_L_bus[win*SLICE_W +: SLICE_W];
      sel_Q = bus.coef_Q_bus[win*SLICE_W +: SLICE_W];
   end

   // Beat mux towards the core, valid only while feeding.
   always_comb begin
      core_in_valid = (state == FEED);
      case (beat)
         2'd0: begin
            feed_L = cap_a;
            feed_Q = cap_m;
         end
         2'd1: begin
            feed_L = cap_b;
            feed_Q = cap_n;
         end
         default: begin
            feed_L = cap_c;
            feed_Q = cap_k;
         end
      endcase
   end

   // Job FSM with capture and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= 2'd3;
         beat        <= '0;
         cap_a       <= '0;
         cap_b       <= '0;
         cap_c       <= '0;
         cap_m       <= '0;
         cap_n       <= '0;
         cap_k       <= '0;
         gnt_r       <= '0;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_id_r    <= '0;
         out_r       <= '0;
      end else begin
         gnt_r       <= '0;
         out_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               // busy drops after the result cycle unless a new job is taken
               busy_r <= found;
               if (found) begin
                  ptr                   <= win;
                  gnt_r                 <= gnt_next;
                  {cap_c, cap_b, cap_a} <= sel_L;
                  {cap_k, cap_n, cap_m} <= sel_Q;
                  beat                  <= '0;
                  state                 <= FEED;
               end
            end
            FEED: begin
               if (beat == 2'd2) begin
                  beat  <= '0;
                  state <= WAIT;
               end else begin
                  beat <= beat + 2'd1;
               end
            end
            WAIT: begin
               if (core_out_valid) begin
                  out_valid_r <= 1'b1;
                  out_id_r    <= ptr;
                  out_r       <= core_out;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.busy      = busy_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_id    = out_id_r;
   assign bus.out       = out_r;

   RCL #(
      .COEF_W (COEF_W)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (core_in_valid),
      .coef_L    (feed_L),
      .coef_Q    (feed_Q),
      .out_valid (core_out_valid),
      .out       (core_out)
   );

endmodule
